// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg
//   Shared definitions for the USB receive path: CRC16 constants, the
//   checker state encoding and the per-bit CRC16 update function. The TX
//   CRC generator uses the same constants and function.
package usb_rx_pkg;

    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_PRESET   = 16'hFFFF;
    // Register value left behind when a good packet, including its inverted
    // CRC field, has been shifted through the LFSR.
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    localparam int          BIT_COUNT_W    = 14;
    localparam logic [13:0] BIT_COUNT_MAX  = 14'h3FFF;
    localparam logic [13:0] MIN_PKT_BITS   = 14'd16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } rx_state_t;

    // One serial CRC16 step; bits enter at the top of the register.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/crc16_lfsr.sv
// crc16_lfsr
//   Serial CRC16 register: combinational next value plus an enable-gated
//   register with a synchronous preset load. Shared between RX and TX.
// Ports:
//   clk     in   clock, rising edge
//   n_rst   in   asynchronous active-low reset (register -> preset)
//   load    in   synchronous preset load, wins over enable
//   enable  in   shift bit_in into the register this cycle
//   bit_in  in   serial input bit
//   crc     out  current register contents
module crc16_lfsr
    import usb_rx_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        load,
    input  logic        enable,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] crc_next;

    always_comb begin
        crc_next = crc16_step(crc, bit_in);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc <= CRC16_PRESET;
        end else if (load) begin
            crc <= CRC16_PRESET;
        end else if (enable) begin
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/usb_rx_crc16_checker.sv
// usb_rx_crc16_checker
//   Accumulates the CRC16 over the de-stuffed bits of a USB data packet
//   (payload plus CRC field) and reports whether the residual matched.
// Ports:
//   clk        in   clock, rising edge
//   n_rst      in   asynchronous active-low reset
//   sop        in   start-of-packet strobe, restarts from any state
//   bit_valid  in   bit_in carries a new bit this cycle
//   bit_in     in   received bit, wire order
//   eop        in   end-of-packet strobe
//   busy       out  high in ACCUM and CHECK
//   done       out  one-cycle verdict-valid pulse
//   crc_ok     out  residual matched (held until next sop)
//   crc_err    out  mismatch or short packet (held until next sop)
//   short_pkt  out  fewer than 16 bits received (held until next sop)
//   crc_reg    out  live LFSR contents
//   bit_count  out  accepted bits since sop, saturating
module usb_rx_crc16_checker
    import usb_rx_pkg::*;
(
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   sop,
    input  logic                   bit_valid,
    input  logic                   bit_in,
    input  logic                   eop,
    output logic                   busy,
    output logic                   done,
    output logic                   crc_ok,
    output logic                   crc_err,
    output logic                   short_pkt,
    output logic [15:0]            crc_reg,
    output logic [BIT_COUNT_W-1:0] bit_count
);

    rx_state_t state;
    logic      accept_bit;
    logic      is_short;

    // A bit arriving together with sop belongs to no packet and is dropped.
    assign accept_bit = (state == ST_ACCUM) && bit_valid && !sop;
    assign is_short   = (bit_count < MIN_PKT_BITS);

    crc16_lfsr u_lfsr (
        .clk    (clk),
        .n_rst  (n_rst),
        .load   (sop),
        .enable (accept_bit),
        .bit_in (bit_in),
        .crc    (crc_reg)
    );

    // Control FSM with registered status outputs. sop has priority over
    // everything so that a restart from CHECK or DONE discards the verdict.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            bit_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            crc_ok    <= 1'b0;
            crc_err   <= 1'b0;
            short_pkt <= 1'b0;
        end else if (sop) begin
            state     <= ST_ACCUM;
            bit_count <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            crc_ok    <= 1'b0;
            crc_err   <= 1'b0;
            short_pkt <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (accept_bit && (bit_count != BIT_COUNT_MAX)) begin
                        bit_count <= bit_count + 14'd1;
                    end
                    if (eop) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    short_pkt <= is_short;
                    crc_ok    <= !is_short && (crc_reg == CRC16_RESIDUAL);
                    crc_err   <= !(!is_short && (crc_reg == CRC16_RESIDUAL));
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
